// File: rtl/fb_scan_reader_pkg.sv
// Shared types and constants for the frame-buffer scan reader
// and the frame memory slave it talks to.
package fb_scan_reader_pkg;

   localparam int DEF_ADDR_W = 18;
   localparam int DEF_DATA_W = 16;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } scan_state_e;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fb_scan_reader_scan_fifo.sv
// Small synchronous FIFO for the scan reader's pixel output,
// with a synchronous flush used while scanning is disabled.
module scan_fifo
   import fb_scan_reader_pkg::*;
#(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/fb_scan_reader.sv
// Sequential frame-memory read master feeding a valid/ready pixel stream.
// Optional FB_SCAN_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module fb_scan_reader
   import fb_scan_reader_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int BASE       = 0,
   parameter int WORDS      = 4096,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              a_clk,
   input  logic              a_rst,
   input  logic              enable,
   output logic              ar_valid,
   input  logic              ar_ready,
   output logic [ADDR_W-1:0] ar_addr,
   output logic              ar_prot,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [DATA_W-1:0] r_data,
   input  logic [1:0]        r_resp,
   output logic              px_valid,
   input  logic              px_ready,
   output logic [DATA_W-1:0] px_data,
   output logic              px_sof,
   output logic              px_eof,
   output logic              err_sticky
`ifdef FB_SCAN_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       underrun_cnt
`endif
);

   localparam int CW = cnt_width(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(BASE);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BASE + WORDS - 1);

   scan_state_e       state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              arv_q, arv_d;
   logic              rrdy_q, rrdy_d;
   logic              err_q, err_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_flush;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [DATA_W+1:0] fifo_wdata;
   logic [DATA_W+1:0] fifo_rdata;
   logic              slot_free;

   assign slot_free = (fifo_count < CW'(FIFO_DEPTH));

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      arv_d      = arv_q;
      rrdy_d     = rrdy_q;
      err_d      = err_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      unique case (1'b1)
         (state_q == ST_IDLE): begin
            if (enable) begin
               if (slot_free) begin
                  state_d = ST_ADDR;
                  arv_d   = 1'b1;
               end
            end else begin
               ptr_d      = FIRST;
               fifo_flush = 1'b1;
            end
         end
         (state_q == ST_ADDR): begin
            if (ar_ready) begin
               arv_d   = 1'b0;
               rrdy_d  = 1'b1;
               state_d = ST_DATA;
            end
         end
         (state_q == ST_DATA): begin
            if (r_valid) begin
               fifo_push = !fifo_full;
               rrdy_d    = 1'b0;
               ptr_d     = (ptr_q == LAST) ? FIRST : ptr_q + 1'b1;
               if (r_resp != RESP_OKAY) err_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            arv_d   = 1'b0;
            rrdy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge a_clk or negedge a_rst) begin
      if (!a_rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= FIRST;
         arv_q   <= 1'b0;
         rrdy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         arv_q   <= arv_d;
         rrdy_q  <= rrdy_d;
         err_q   <= err_d;
      end
   end

   // Tags come from the pointer of the word being returned, not ar_addr.
   assign fifo_wdata = {r_data, (ptr_q == FIRST), (ptr_q == LAST)};
   assign fifo_pop   = px_valid && px_ready;

   scan_fifo #(
      .WIDTH (DATA_W + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (a_clk),
      .rst_ni  (a_rst),
      .flush_i (fifo_flush),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign ar_valid   = arv_q;
   assign ar_addr    = ptr_q;
   assign ar_prot    = 1'b0;
   assign r_ready    = rrdy_q;
   assign err_sticky = err_q;
   assign px_valid   = !fifo_empty;
   assign {px_data, px_sof, px_eof} = fifo_empty ? '0 : fifo_rdata;

`ifdef FB_SCAN_UNDERRUN_CNT_EN
   logic [15:0] urun_q, urun_d;
   logic        armed_q, armed_d;

   // Starved cycles only count once the frame head has been consumed.
   always_comb begin
      urun_d  = urun_q;
      armed_d = armed_q;
      if (!enable) begin
         urun_d  = '0;
         armed_d = 1'b0;
      end else begin
         if (fifo_pop && px_sof) armed_d = 1'b1;
         if (armed_q && px_ready && !px_valid && (urun_q != 16'hFFFF))
            urun_d = urun_q + 1'b1;
      end
   end

   always_ff @(posedge a_clk or negedge a_rst) begin
      if (!a_rst) begin
         urun_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         urun_q  <= urun_d;
         armed_q <= armed_d;
      end
   end

   assign underrun_cnt = urun_q;
`endif

endmodule
